// File: rtl/sevenseg_capture.sv
// Receive side of an 8-digit multiplexed seven-segment display: watches the active-low
// anode strobes and segment lines and rebuilds the displayed 32-bit hex value per sweep.
module sevenseg_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  sevenSeg,
  input  logic [7:0]  AN,
  output logic [31:0] number_out,
  output logic [7:0]  digit_enable,
  output logic        number_valid,
  output logic        seg_error
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [7:0]  an_s1_q, an_s2_q;
  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [14:0] prev_q;
  state_t      state_q, state_d;
  logic [15:0] settle_q, settle_d;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] number_q;
  logic [7:0]  enable_q;
  logic        valid_q, err_q;

  logic [7:0]  an_low;
  logic        blank, single, changed;
  logic [2:0]  idx;
  logic [7:0]  onehot_idx;
  logic        seg_ok;
  logic [3:0]  nib;
  logic        do_sample, store, bad_sample, wrap, tmo_hit, publish;
  logic [31:0] masked;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign an_low     = ~an_s2_q;
  assign blank      = (an_s2_q == 8'hFF);
  assign single     = $onehot(an_low);
  assign changed    = ({an_s2_q, seg_s2_q} != prev_q);
  assign {seg_ok, nib} = decode(seg_s2_q);
  assign onehot_idx = 8'd1 << idx;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
  end

  // Slots not lit during the frame read as zero rather than stale shadow data.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign masked[4*gi +: 4] = seen_q[gi] ? shadow_q[4*gi +: 4] : 4'h0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    do_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (!blank) begin
          state_d  = SETTLE;
          settle_d = 16'd0;
        end
      end
      SETTLE: begin
        if (blank) begin
          state_d = IDLE;
        end else if (changed) begin
          settle_d = 16'd0;
        end else if (settle_q == 16'(SETTLE_CYCLES - 1)) begin
          // Errors also park in HOLD so a stable bad strobe reports only once.
          do_sample = 1'b1;
          state_d   = HOLD;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      HOLD: begin
        if (changed) begin
          settle_d = 16'd0;
          state_d  = blank ? IDLE : SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign store      = do_sample && single && seg_ok;
  assign bad_sample = do_sample && !(single && seg_ok);
  assign wrap       = store && seen_q[idx];
  assign tmo_hit    = !store && (tmo_q == 24'(TIMEOUT_CYCLES - 1));
  assign publish    = wrap || (tmo_hit && (seen_q != 8'd0));

  always_comb begin
    seen_d   = seen_q;
    shadow_d = shadow_q;
    tmo_d    = tmo_q + 24'd1;
    if (store) begin
      tmo_d = 24'd0;
      shadow_d[{idx, 2'b00} +: 4] = nib;
      seen_d = wrap ? onehot_idx : (seen_q | onehot_idx);
    end else if (tmo_hit) begin
      tmo_d  = 24'd0;
      seen_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1_q  <= 8'hFF;
      an_s2_q  <= 8'hFF;
      seg_s1_q <= 7'h7F;
      seg_s2_q <= 7'h7F;
      prev_q   <= 15'h7FFF;
      state_q  <= IDLE;
      settle_q <= 16'd0;
      tmo_q    <= 24'd0;
      seen_q   <= 8'd0;
      shadow_q <= 32'd0;
      number_q <= 32'd0;
      enable_q <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      an_s1_q  <= AN;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= sevenSeg;
      seg_s2_q <= seg_s1_q;
      prev_q   <= {an_s2_q, seg_s2_q};
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      valid_q  <= publish;
      err_q    <= bad_sample;
      if (publish) begin
        number_q <= masked;
        enable_q <= seen_q;
      end
    end
  end

  assign number_out   = number_q;
  assign digit_enable = enable_q;
  assign number_valid = valid_q;
  assign seg_error    = err_q;

endmodule
